rr_mux_arbiter: RTL and testbench

- Upstream control stage for the 32-bit 4-to-1 operand mux (mux4to1); it drives that mux's `select` input.
- Arbitrates among four requesters with round-robin fairness.
- Captures the mux output into a single-entry registered output stage with a valid/ready handshake.
- Sits between four operand sources and the downstream consumer (ALU/operand latch).

---
 rtl/rr_mux_arbiter.sv | 104 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a 4:1 operand mux select, with a single-entry
// registered output stage (valid/ready) that captures the selected word.
//
// state | meaning
// EMPTY | output register holds nothing; any request can be captured
// FULL  | output register holds a word for the consumer
module rr_mux_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_i,
  output logic [3:0]       gnt_o,
  output logic [1:0]       select_o,
  input  logic [WIDTH-1:0] mux_out_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       out_src_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       any_req;
  logic       can_load;
  logic       capture;

  // Search starts at the pointer and wraps modulo 4.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req     = |req_i;
  assign out_valid_o = (state_q == FULL);
  assign can_load    = (state_q == EMPTY) | (out_ready_i & out_valid_o);
  assign capture     = can_load & any_req;
  assign select_o    = any_req ? winner : ptr_q;
  assign gnt_o       = capture ? (4'b0001 << winner) : 4'b0000;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    case (state_q)
      EMPTY: begin
        if (capture) begin
          state_d = FULL;
        end
      end
      FULL: begin
        // A drain and a capture in the same cycle keep the stage full.
        if (capture) begin
          state_d = FULL;
        end else if (out_ready_i) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (capture) begin
      out_data_d = mux_out_i;
      out_src_d  = winner;
      ptr_d      = winner + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      ptr_q      <= 2'd0;
      out_data_q <= '0;
      out_src_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model.
module tb_rr_mux_arbiter;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req = 4'b0000;
  logic [3:0]       gnt;
  logic [1:0]       select;
  logic [WIDTH-1:0] mux_out;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_valid;
  logic             out_ready = 1'b0;

  logic [WIDTH-1:0] in_d [4];

  assign mux_out = in_d[select];

  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .gnt_o       (gnt),
    .select_o    (select),
    .mux_out_i   (mux_out),
    .out_data_o  (out_data),
    .out_src_o   (out_src),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  int          m_ptr;
  int          m_src;
  bit          m_valid;
  logic [31:0] m_data;
  int          waited [4];

  logic [3:0] last_gnt;
  logic [1:0] last_sel;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_src = 0;
    m_valid = 0;
    m_data = 0;
    for (int i = 0; i < 4; i++) waited[i] = 0;
  endtask

  // Called just after a rising edge: apply inputs, check the combinational
  // decision, then check the registered result after the next edge.
  task automatic cycle(input logic [3:0] r, input logic rdy);
    int  win;
    bit  cap;
    logic [31:0] cap_data;
    req = r;
    out_ready = rdy;
    #3;
    win = -1;
    for (int k = 0; k < 4; k++) begin
      if (win < 0 && r[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    end
    cap = (!m_valid || rdy) && (win >= 0);
    last_gnt = gnt;
    last_sel = select;
    check_val("select", 32'(select), 32'((win >= 0) ? win : m_ptr));
    check_val("gnt", 32'(gnt), cap ? (32'd1 << win) : 32'd0);
    check_val("valid_pre", 32'(out_valid), 32'(m_valid));
    cap_data = in_d[(win >= 0) ? win : 0];
    @(posedge clk);
    if (cap) begin
      for (int i = 0; i < 4; i++) begin
        if (i == win) begin
          check_val("starve", 32'(waited[i] < 4), 32'd1);
          waited[i] = 0;
        end else if (r[i]) begin
          waited[i]++;
        end else begin
          waited[i] = 0;
        end
      end
      m_data = cap_data;
      m_src = win;
      m_valid = 1;
      m_ptr = (win + 1) % 4;
    end else begin
      for (int i = 0; i < 4; i++) if (!r[i]) waited[i] = 0;
      if (m_valid && rdy) m_valid = 0;
    end
    #1;
    check_val("valid", 32'(out_valid), 32'(m_valid));
    check_val("src", 32'(out_src), 32'(m_src));
    check_val("data", out_data, m_data);
  endtask

  initial begin
    in_d[0] = 32'h000000ff;
    in_d[1] = 32'h0000ffff;
    in_d[2] = 32'h00ffffff;
    in_d[3] = 32'hffffffff;
    model_reset();
    #2;
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_select", 32'(select), 32'd0);
    check_val("rst_data", out_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single source
    cycle(4'b0100, 1'b1);
    check_val("single_sel", 32'(last_sel), 32'd2);
    check_val("single_gnt", 32'(last_gnt), 32'b0100);
    check_val("single_data", out_data, 32'h00ffffff);
    check_val("single_src", 32'(out_src), 32'd2);
    cycle(4'b0000, 1'b1);
    check_val("drain_keep", out_data, 32'h00ffffff);
    cycle(4'b0000, 1'b1);
    check_val("ptr_after_single", 32'(select), 32'd3);

    // async reset while full
    cycle(4'b0001, 1'b1);
    check_val("full_before_rst", 32'(out_valid), 32'd1);
    req = 4'b0000;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_valid", 32'(out_valid), 32'd0);
    check_val("async_data", out_data, 32'd0);
    check_val("async_gnt", 32'(gnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // round-robin with all requesting
    for (int n = 0; n < 5; n++) begin
      cycle(4'b1111, 1'b1);
      check_val("rr_src", 32'(out_src), 32'(n % 4));
      check_val("rr_onehot", 32'($countones(last_gnt)), 32'd1);
    end
    cycle(4'b1111, 1'b1);
    check_val("bp_src", 32'(out_src), 32'd1);
    for (int n = 0; n < 3; n++) begin
      cycle(4'b1111, 1'b0);
      check_val("bp_gnt", 32'(last_gnt), 32'd0);
      check_val("bp_data", out_data, 32'h0000ffff);
    end
    cycle(4'b1111, 1'b1);
    check_val("bp_release_gnt", 32'(last_gnt), 32'b0100);
    check_val("bp_release_src", 32'(out_src), 32'd2);
    cycle(4'b1000, 1'b1);
    cycle(4'b0011, 1'b1);
    check_val("wrap_sel", 32'(last_sel), 32'd0);
    cycle(4'b0011, 1'b1);
    check_val("wrap_next", 32'(out_src), 32'd1);
    cycle(4'b0000, 1'b1);
    check_val("drain_valid", 32'(out_valid), 32'd0);
    check_val("drain_data", out_data, 32'h0000ffff);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) in_d[i] = $urandom;
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
